// File: rtl/dac_spi_tx_if.sv
// dac_spi_tx_if -- sample handshake and DAC pin bundle for dac_spi_tx.
//
// Signals:
//   sample_a[11:0]  channel A sample (serialised on dac_d0)
//   sample_b[11:0]  channel B sample (serialised on dac_d1)
//   pd_mode[1:0]    DAC power-down bits, sent in both frames
//   sample_valid    producer has a sample pair
//   sample_ready    transmitter can accept a sample pair
//   busy            frame or inter-frame gap in progress
//   frame_done      one-cycle pulse when SYNC returns high
//   dac_sync        DAC SYNC, active low
//   dac_sclk        DAC serial clock, idles high
//   dac_d0/dac_d1   serial data, channel A / channel B
//
// Modports:
//   master  sample producer side (drives samples, observes status and pins)
//   slave   dac_spi_tx side
`timescale 1ns/1ps

interface dac_spi_tx_if;
    logic [11:0] sample_a;
    logic [11:0] sample_b;
    logic [1:0]  pd_mode;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        frame_done;
    logic        dac_sync;
    logic        dac_sclk;
    logic        dac_d0;
    logic        dac_d1;

    modport master (
        output sample_a, sample_b, pd_mode, sample_valid,
        input  sample_ready, busy, frame_done, dac_sync, dac_sclk, dac_d0, dac_d1
    );

    modport slave (
        input  sample_a, sample_b, pd_mode, sample_valid,
        output sample_ready, busy, frame_done, dac_sync, dac_sclk, dac_d0, dac_d1
    );
endinterface

// File: rtl/dac_spi_tx.sv
// dac_spi_tx -- SPI transmitter for a dual-channel 12-bit DAC (SYNC/SCLK/D0/D1).
//
// Accepts a sample pair on a valid/ready handshake and shifts out one 16-bit
// word per channel, MSB first: {2'b00, pd_mode, sample}. SCLK idles high;
// data changes only on rising SCLK so the DAC samples it on the falling edge.
// Each frame holds SYNC low for 32*CLK_DIV cycles (16 falling SCLK edges),
// followed by GAP_CYCLES cycles of SYNC high before the next accept.
//
// Parameters:
//   CLK_DIV     CLK cycles per SCLK half-period (>= 1)
//   GAP_CYCLES  CLK cycles SYNC stays high between frames (>= 1)
//
// Ports:
//   CLK     system clock
//   resetn  asynchronous active-low reset; aborts any frame in flight
//   bus     dac_spi_tx_if.slave: sample handshake, status, DAC pins
//
// Build option:
//   DAC_SIGNED_IN_EN  when defined, samples are two's complement and are
//                     converted to offset binary (bit 11 inverted) at latch.
//
// All outputs are registered: the output process computes next-cycle values
// from the next state and next shift contents.
`timescale 1ns/1ps

module dac_spi_tx #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        resetn,
    dac_spi_tx_if.slave bus
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t state, next_state;

    logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
    logic [4:0]       half_cnt, half_cnt_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
    logic [15:0]      shift_a, shift_a_nxt;
    logic [15:0]      shift_b, shift_b_nxt;
    logic [11:0]      field_a, field_b;

    logic accept;
    logic half_wrap;
    logic last_half;
    logic gap_end;

    logic sync_nxt, sclk_nxt, d0_nxt, d1_nxt;
    logic ready_nxt, busy_nxt, done_nxt;

`ifdef DAC_SIGNED_IN_EN
    assign field_a = {~bus.sample_a[11], bus.sample_a[10:0]};
    assign field_b = {~bus.sample_b[11], bus.sample_b[10:0]};
`else
    assign field_a = bus.sample_a;
    assign field_b = bus.sample_b;
`endif

    // sample_ready is high exactly while IDLE, so this is valid && ready.
    assign accept    = (state == IDLE) && bus.sample_valid;
    assign half_wrap = (state == SHIFT) && (div_cnt == DIV_LAST);
    assign last_half = half_wrap && (half_cnt == 5'd31);
    assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);

    // State register
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept)    next_state = SHIFT;
            SHIFT:   if (last_half) next_state = GAP;
            GAP:     if (gap_end)   next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    // Counter and shift-register next values
    always_comb begin
        div_cnt_nxt  = '0;
        half_cnt_nxt = '0;
        gap_cnt_nxt  = '0;
        shift_a_nxt  = shift_a;
        shift_b_nxt  = shift_b;
        case (state)
            IDLE: begin
                if (accept) begin
                    shift_a_nxt = {2'b00, bus.pd_mode, field_a};
                    shift_b_nxt = {2'b00, bus.pd_mode, field_b};
                end
            end
            SHIFT: begin
                div_cnt_nxt  = half_wrap ? '0 : div_cnt + DIV_W'(1);
                half_cnt_nxt = half_wrap ? half_cnt + 5'd1 : half_cnt;
                // SCLK low and about to wrap: rising edge, present the next bit.
                if (half_wrap && !bus.dac_sclk) begin
                    shift_a_nxt = {shift_a[14:0], 1'b0};
                    shift_b_nxt = {shift_b[14:0], 1'b0};
                end
            end
            GAP: begin
                gap_cnt_nxt = gap_cnt + GAP_W'(1);
            end
            default: ;
        endcase
    end

    // Output next values, derived from where the FSM is heading
    always_comb begin
        ready_nxt = (next_state == IDLE);
        busy_nxt  = (next_state != IDLE);
        sync_nxt  = (next_state != SHIFT);
        done_nxt  = last_half;
        sclk_nxt  = 1'b1;
        d0_nxt    = 1'b0;
        d1_nxt    = 1'b0;
        if (next_state == SHIFT) begin
            // SCLK is already high on entry from IDLE and half_wrap is 0 there,
            // so the toggle expression also covers the first SHIFT cycle.
            sclk_nxt = bus.dac_sclk ^ half_wrap;
            d0_nxt   = shift_a_nxt[15];
            d1_nxt   = shift_b_nxt[15];
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            div_cnt          <= '0;
            half_cnt         <= '0;
            gap_cnt          <= '0;
            shift_a          <= '0;
            shift_b          <= '0;
            bus.sample_ready <= 1'b1;
            bus.busy         <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.dac_sync     <= 1'b1;
            bus.dac_sclk     <= 1'b1;
            bus.dac_d0       <= 1'b0;
            bus.dac_d1       <= 1'b0;
        end else begin
            div_cnt          <= div_cnt_nxt;
            half_cnt         <= half_cnt_nxt;
            gap_cnt          <= gap_cnt_nxt;
            shift_a          <= shift_a_nxt;
            shift_b          <= shift_b_nxt;
            bus.sample_ready <= ready_nxt;
            bus.busy         <= busy_nxt;
            bus.frame_done   <= done_nxt;
            bus.dac_sync     <= sync_nxt;
            bus.dac_sclk     <= sclk_nxt;
            bus.dac_d0       <= d0_nxt;
            bus.dac_d1       <= d1_nxt;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx -- bench for dac_spi_tx.
// Two instances share clock and reset: u_dut0 with CLK_DIV=4/GAP_CYCLES=4 and
// u_dut1 with CLK_DIV=1/GAP_CYCLES=1. Expected frame words are queued when a
// sample pair is accepted; a monitor rebuilds each frame from the data seen on
// falling SCLK edges and compares it when SYNC returns high.
`timescale 1ns/1ps

module tb_dac_spi_tx;

    logic clk;
    logic resetn;

    dac_spi_tx_if bus0 ();
    dac_spi_tx_if bus1 ();

    logic [11:0] sa [2];
    logic [11:0] sb [2];
    logic [1:0]  pd [2];
    logic [1:0]  vld;

    logic [1:0] sync_w, sclk_w, d0_w, d1_w, rdy_w, busy_w, fd_w;

    assign bus0.sample_a     = sa[0];
    assign bus0.sample_b     = sb[0];
    assign bus0.pd_mode      = pd[0];
    assign bus0.sample_valid = vld[0];
    assign bus1.sample_a     = sa[1];
    assign bus1.sample_b     = sb[1];
    assign bus1.pd_mode      = pd[1];
    assign bus1.sample_valid = vld[1];

    assign sync_w = {bus1.dac_sync,     bus0.dac_sync};
    assign sclk_w = {bus1.dac_sclk,     bus0.dac_sclk};
    assign d0_w   = {bus1.dac_d0,       bus0.dac_d0};
    assign d1_w   = {bus1.dac_d1,       bus0.dac_d1};
    assign rdy_w  = {bus1.sample_ready, bus0.sample_ready};
    assign busy_w = {bus1.busy,         bus0.busy};
    assign fd_w   = {bus1.frame_done,   bus0.frame_done};

    dac_spi_tx #(.CLK_DIV(4), .GAP_CYCLES(4)) u_dut0 (
        .CLK    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    dac_spi_tx #(.CLK_DIV(1), .GAP_CYCLES(1)) u_dut1 (
        .CLK    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model_word(input logic [1:0] p, input logic [11:0] s);
`ifdef DAC_SIGNED_IN_EN
        return {2'b00, p, s ^ 12'h800};
`else
        return {2'b00, p, s};
`endif
    endfunction

    // ---------------- scoreboard and monitor ----------------
    typedef struct {
        int          id;
        logic [15:0] wa;
        logic [15:0] wb;
    } exp_t;

    exp_t exp_q[$];

    int          nbits   [2];
    int          low_len [2];
    int          fd_cnt  [2] = '{0, 0};
    int          frames  [2] = '{0, 0};
    logic [15:0] cap_a   [2];
    logic [15:0] cap_b   [2];
    logic        psync   [2];
    logic        psclk   [2];
    int          exp_low [2] = '{128, 32};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!resetn) begin
                nbits[i]   = 0;
                low_len[i] = 0;
                psync[i]   = 1'b1;
                psclk[i]   = 1'b1;
            end else begin
                if (!sync_w[i]) begin
                    low_len[i]++;
                    if (psclk[i] && !sclk_w[i]) begin
                        cap_a[i] = {cap_a[i][14:0], d0_w[i]};
                        cap_b[i] = {cap_b[i][14:0], d1_w[i]};
                        nbits[i]++;
                    end
                end
                if (fd_w[i]) fd_cnt[i]++;
                if (!psync[i] && sync_w[i]) begin
                    exp_t e;
                    check($sformatf("falling_edges_dut%0d", i), nbits[i], 16);
                    check($sformatf("sync_low_len_dut%0d", i), low_len[i], exp_low[i]);
                    check($sformatf("frame_done_at_sync_rise_dut%0d", i), fd_w[i], 1);
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_frame_dut%0d", i), 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        check($sformatf("frame_owner_dut%0d", i), e.id, i);
                        check($sformatf("d0_word_dut%0d", i), cap_a[i], e.wa);
                        check($sformatf("d1_word_dut%0d", i), cap_b[i], e.wb);
                    end
                    frames[i]++;
                    nbits[i]   = 0;
                    low_len[i] = 0;
                end
                psync[i] = sync_w[i];
                psclk[i] = sclk_w[i];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int id, input logic [11:0] a, input logic [11:0] b,
                        input logic [1:0] p, input logic [15:0] ea, input logic [15:0] eb);
        int n;
        int lat;
        lat = (id == 0) ? 133 : 34;
        @(negedge clk);
        sa[id] = a; sb[id] = b; pd[id] = p; vld[id] = 1'b1;
        n = 0;
        while (!rdy_w[id] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_w[id]) begin
            check($sformatf("accept_timeout_dut%0d", id), 0, 1);
            vld[id] = 1'b0;
            return;
        end
        exp_q.push_back('{id: id, wa: ea, wb: eb});
        @(posedge clk);
        #1;
        // Scramble inputs right after accept: the frame in flight must not change.
        vld[id] = 1'b0; sa[id] = ~a; sb[id] = ~b; pd[id] = ~p;
        check($sformatf("sync_after_accept_dut%0d", id), sync_w[id], 0);
        check($sformatf("ready_after_accept_dut%0d", id), rdy_w[id], 0);
        check($sformatf("busy_after_accept_dut%0d", id), busy_w[id], 1);
        check($sformatf("d0_first_bit_dut%0d", id), d0_w[id], ea[15]);
        n = 1;
        while (!rdy_w[id] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("ready_latency_dut%0d", id), n, lat);
    endtask

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic [1:0]  p;
        logic [15:0] ea_u;
        logic [15:0] eb_u;
        logic [15:0] ea_s;
        logic [15:0] eb_s;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd_before;
        int fr_before;
        int t_prev;
        int t_now;
        int n;
        int k;
        logic prev_sclk;
        logic [15:0] ea, eb;

        tbl[0] = '{12'hABC, 12'h123, 2'b00, 16'h0ABC, 16'h0123, 16'h02BC, 16'h0923};
        tbl[1] = '{12'hFFF, 12'h000, 2'b11, 16'h3FFF, 16'h3000, 16'h37FF, 16'h3800};
        tbl[2] = '{12'h800, 12'h7FF, 2'b01, 16'h1800, 16'h17FF, 16'h1000, 16'h1FFF};
        tbl[3] = '{12'h555, 12'hAAA, 2'b10, 16'h2555, 16'h2AAA, 16'h2D55, 16'h22AA};
        tbl[4] = '{12'h000, 12'hFFF, 2'b00, 16'h0000, 16'h0FFF, 16'h0800, 16'h07FF};
        tbl[5] = '{12'h7FF, 12'h800, 2'b00, 16'h07FF, 16'h0800, 16'h0FFF, 16'h0000};

        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            sa[i] = '0; sb[i] = '0; pd[i] = '0;
        end
        vld = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_sync_dut%0d", i),  sync_w[i], 1);
            check($sformatf("rst_sclk_dut%0d", i),  sclk_w[i], 1);
            check($sformatf("rst_d0_dut%0d", i),    d0_w[i],   0);
            check($sformatf("rst_d1_dut%0d", i),    d1_w[i],   0);
            check($sformatf("rst_ready_dut%0d", i), rdy_w[i],  1);
            check($sformatf("rst_busy_dut%0d", i),  busy_w[i], 0);
            check($sformatf("rst_done_dut%0d", i),  fd_w[i],   0);
        end
        resetn = 1'b1;

        // Table vectors on both instances
        for (int id = 0; id < 2; id++) begin
            for (int v = 0; v < 6; v++) begin
`ifdef DAC_SIGNED_IN_EN
                ea = tbl[v].ea_s; eb = tbl[v].eb_s;
`else
                ea = tbl[v].ea_u; eb = tbl[v].eb_u;
`endif
                send(id, tbl[v].a, tbl[v].b, tbl[v].p, ea, eb);
            end
        end

        // Back-to-back: valid held high with incrementing samples
        fd_before = fd_cnt[0];
        fr_before = frames[0];
        t_prev = 0;
        vld[0] = 1'b1;
        for (int f = 0; f < 4; f++) begin
            sa[0] = 12'h100 + 12'(f);
            sb[0] = 12'hE00 - 12'(f);
            pd[0] = 2'(f);
            @(negedge clk);
            n = 0;
            while (!rdy_w[0] && n < 2000) begin
                @(negedge clk);
                n++;
            end
            if (!rdy_w[0]) begin
                check("b2b_accept_timeout", 0, 1);
                break;
            end
            exp_q.push_back('{id: 0, wa: model_word(pd[0], sa[0]), wb: model_word(pd[0], sb[0])});
            @(posedge clk);
            #1;
            t_now = cyc;
            if (f > 0) check($sformatf("b2b_accept_spacing_%0d", f), t_now - t_prev, 133);
            t_prev = t_now;
        end
        vld[0] = 1'b0;
        n = 0;
        while (!rdy_w[0] && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("b2b_frames", frames[0] - fr_before, 4);
        check("b2b_frame_done_count", fd_cnt[0] - fd_before, 4);

        // Reset at the 7th falling SCLK edge of a frame
        fd_before = fd_cnt[0];
        fr_before = frames[0];
        @(negedge clk);
        sa[0] = 12'h321; sb[0] = 12'h654; pd[0] = 2'b10; vld[0] = 1'b1;
        @(posedge clk);
        #1;
        vld[0] = 1'b0;
        check("abort_frame_started", sync_w[0], 0);
        k = 0;
        n = 0;
        prev_sclk = sclk_w[0];
        while (k < 7 && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (prev_sclk && !sclk_w[0]) k++;
            prev_sclk = sclk_w[0];
        end
        check("abort_reached_7th_fall", k, 7);
        resetn = 1'b0;
        #1;
        check("abort_sync", sync_w[0], 1);
        check("abort_sclk", sclk_w[0], 1);
        check("abort_d0",   d0_w[0],   0);
        check("abort_busy", busy_w[0], 0);
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("abort_ready_after_release", rdy_w[0], 1);
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_frame_done", fd_cnt[0] - fd_before, 0);
        check("abort_no_frame", frames[0] - fr_before, 0);
        send(0, 12'h5A5, 12'hA5A, 2'b01, model_word(2'b01, 12'h5A5), model_word(2'b01, 12'hA5A));

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        check("frame_done_matches_frames_dut0", fd_cnt[0], frames[0]);
        check("frame_done_matches_frames_dut1", fd_cnt[1], frames[1]);
        check("frames_dut1", frames[1], 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
